mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back select for the 5-stage MIPS core.
- Sits directly upstream of the register file: captures memory-stage results, aligns and extends load data, and drives WriteReg, WriteData and Reg_write_Control.
- Also reports alignment faults and keeps a retired-instruction counter for debug and CPI measurement.

Parameters:
- DW, 32, data width (fixed 32 for MIPS-I; parameterised for the bench only).
- RW, 5, register index width.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Stall  in  1  hold the stage contents.
- Flush  in  1  insert a bubble on the next edge; priority over Stall.
- in_valid  in  1  MEM stage holds a real instruction.
- in_RegWrite  in  1  instruction writes a register.
- in_WbSel  in  2  00 ALU result, 01 load data, 10 PC+8 (link), 11 reserved (treated as 00).
- in_LoadType  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW.
- in_AddrLow  in  2  byte address bits [1:0] of the load.
- in_ALUResult  in  DW  ALU output.
- in_MemData  in  DW  raw data-memory word.
- in_PCPlus8  in  DW  link address.
- in_WriteReg  in  RW  destination register.
- WriteReg  out  RW  to register file.
- WriteData  out  DW  to register file.
- Reg_write_Control  out  1  register-file write enable.
- wb_valid  out  1  stage holds a valid instruction (for the forwarding unit).
- AddrErr  out  1  misaligned load in WB.
- retire_count  out  32  instructions retired.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - Clears all stage registers: valid=0 and every field 0.
  - Forces retire_count=0.
  - Resulting outputs: WriteReg=0, WriteData=0, Reg_write_Control=0, wb_valid=0, AddrErr=0.
  - Reset asserted mid-operation discards the in-flight instruction immediately.
- Capture at each posedge:
  - Flush=1: valid<=0; other fields don't-care (hold).
  - Else Stall=1: all fields hold.
  - Else: all in_* fields are loaded.
- Latency: one cycle from MEM inputs to WB outputs. All outputs are combinational from registered state only, with no input-to-output combinational path.
- Load alignment is little-endian; byte k occupies MemData[8k+7:8k].
  - LW: whole word. Misaligned when AddrLow != 00.
  - LH/LHU: halfword at AddrLow[1]*16, sign- or zero-extended. Misaligned when AddrLow[0]=1.
  - LB/LBU: byte selected by AddrLow, sign- or zero-extended. Never misaligned.
- AddrErr = valid & (WbSel==01) & misaligned.
- WriteData:
  - Mux on WbSel: ALU result, aligned load data, or PC+8.
  - Forced to 0 when valid=0.
- Reg_write_Control = valid & RegWrite & (WriteReg != 0) & ~AddrErr. Register $0 is never written.
- Stalled instruction:
  - Keeps Reg_write_Control asserted; the rewrite is idempotent.
  - Is counted only once.
- retire_count:
  - Increments by 1 on a posedge where valid=1 and Stall=0, or where valid=1 and Flush=1. An instruction leaving WB retires; a flush affects only the incoming instruction.
  - Faulting instructions are counted.
  - Wraps 0xFFFFFFFF -> 0 silently.
- Simultaneous Flush and Stall: Flush wins and the current instruction retires.

Decomposition:
- Shared package (mips_pkg):
  - WbSel encodings WB_ALU, WB_MEM, WB_LINK.
  - LoadType encodings LD_W, LD_H, LD_HU, LD_B, LD_BU.
  - REG_ZERO constant.
- Sub-module load_align (combinational): inputs in_MemData, LoadType, AddrLow; outputs aligned data and misaligned flag. Reused later by the store-path byte-enable logic.

Test Plan:
- Reset: hold Resetn=0 with random inputs -> all outputs 0 and retire_count=0. Release Resetn, then present in_valid=1, RegWrite=1, WbSel=00, ALUResult=0x1234_5678, WriteReg=8 -> next cycle WriteReg=8, WriteData=0x12345678, Reg_write_Control=1, retire_count increments to 1 one cycle later.
- Load extension: MemData=0x80FF_7F01 with AddrLow=11 -> LB gives 0xFFFFFF80 and LBU gives 0x00000080. With AddrLow=10 -> LH gives 0xFFFF80FF and LHU gives 0x000080FF. LW with AddrLow=00 -> 0x80FF7F01.
- Faults and $0:
  - LH with AddrLow=01 -> AddrErr=1, Reg_write_Control=0, retire_count still increments.
  - RegWrite=1 with WriteReg=0 -> Reg_write_Control=0.
- Stall/Flush:
  - Stall for 3 cycles -> outputs stable, retire_count increments once.
  - Flush with Stall -> next cycle wb_valid=0, WriteData=0.
- Link and reserved: WbSel=10 with PCPlus8=0x0040_0018, WriteReg=31 -> WriteData=0x00400018. WbSel=11 -> ALU result is selected.
- Wrap and async reset:
  - Preload retire_count=0xFFFFFFFF via force and retire one instruction -> 0x00000000.
  - Drop Resetn mid-cycle -> outputs clear before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core encodings: write-back source select, load types, register $0.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

  // Write-back source select; 2'b11 is reserved and falls back to the ALU path.
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // Load types; unlisted codes behave as LD_W.
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  // Hard-wired zero register; never written.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment and sign/zero extension, plus misalignment detect.
// Latency: purely combinational.
// Backpressure: none.
// Ports: in_MemData (raw word), LoadType, AddrLow -> aligned_data, misaligned.
module load_align
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] in_MemData,
  input  logic [2:0]    LoadType,
  input  logic [1:0]    AddrLow,
  output logic [DW-1:0] aligned_data,
  output logic          misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Byte k lives at bits [8k+7:8k]; halfword chosen by AddrLow[1] only.
  assign sel_byte = in_MemData[{AddrLow, 3'b000} +: 8];
  assign sel_half = AddrLow[1] ? in_MemData[31:16] : in_MemData[15:0];

  always_comb begin
    aligned_data = in_MemData;
    misaligned   = 1'b0;
    case (LoadType)
      LD_W: begin
        aligned_data = in_MemData;
        misaligned   = (AddrLow != 2'b00);
      end
      LD_H: begin
        aligned_data = {{(DW-16){sel_half[15]}}, sel_half};
        misaligned   = AddrLow[0];
      end
      LD_HU: begin
        aligned_data = {{(DW-16){1'b0}}, sel_half};
        misaligned   = AddrLow[0];
      end
      LD_B: begin
        aligned_data = {{(DW-8){sel_byte[7]}}, sel_byte};
        misaligned   = 1'b0;
      end
      LD_BU: begin
        aligned_data = {{(DW-8){1'b0}}, sel_byte};
        misaligned   = 1'b0;
      end
      default: begin
        aligned_data = in_MemData;
        misaligned   = (AddrLow != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, load alignment, fault flag and retire counter.
// Latency: one cycle MEM inputs -> WB outputs; outputs depend on registered state only.
// Backpressure: Stall holds the stage; Flush (wins over Stall) bubbles the incoming slot.
// Ports: Clock, Resetn (async active-low), Stall, Flush, in_* MEM-stage fields;
//        WriteReg/WriteData/Reg_write_Control to the register file, wb_valid for
//        forwarding, AddrErr for misaligned loads, retire_count for debug/CPI.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          in_valid,
  input  logic          in_RegWrite,
  input  logic [1:0]    in_WbSel,
  input  logic [2:0]    in_LoadType,
  input  logic [1:0]    in_AddrLow,
  input  logic [DW-1:0] in_ALUResult,
  input  logic [DW-1:0] in_MemData,
  input  logic [DW-1:0] in_PCPlus8,
  input  logic [RW-1:0] in_WriteReg,
  output logic [RW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  output logic          Reg_write_Control,
  output logic          wb_valid,
  output logic          AddrErr,
  output logic [31:0]   retire_count
);

  logic          valid_q;
  logic          regwrite_q;
  logic [1:0]    wbsel_q;
  logic [2:0]    loadtype_q;
  logic [1:0]    addrlow_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] pc8_q;
  logic [RW-1:0] wreg_q;
  logic [31:0]   retire_cnt_q;

  logic [DW-1:0] load_data;
  logic          load_mis;

  // Stage register. Flush only needs to kill valid; the payload is left alone.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wbsel_q    <= '0;
      loadtype_q <= '0;
      addrlow_q  <= '0;
      alu_q      <= '0;
      mem_q      <= '0;
      pc8_q      <= '0;
      wreg_q     <= '0;
    end else if (Flush) begin
      valid_q    <= 1'b0;
    end else if (!Stall) begin
      valid_q    <= in_valid;
      regwrite_q <= in_RegWrite;
      wbsel_q    <= in_WbSel;
      loadtype_q <= in_LoadType;
      addrlow_q  <= in_AddrLow;
      alu_q      <= in_ALUResult;
      mem_q      <= in_MemData;
      pc8_q      <= in_PCPlus8;
      wreg_q     <= in_WriteReg;
    end
  end

  // The resident instruction leaves WB whenever the stage advances; a flush
  // only discards what is coming in, so the resident one still retires.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      retire_cnt_q <= '0;
    end else if (valid_q && (!Stall || Flush)) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  load_align #(.DW(DW)) u_load_align (
    .in_MemData   (mem_q),
    .LoadType     (loadtype_q),
    .AddrLow      (addrlow_q),
    .aligned_data (load_data),
    .misaligned   (load_mis)
  );

  always_comb begin
    WriteData = '0;
    if (valid_q) begin
      case (wbsel_q)
        WB_MEM:  WriteData = load_data;
        WB_LINK: WriteData = pc8_q;
        default: WriteData = alu_q;
      endcase
    end
  end

  assign AddrErr           = valid_q & (wbsel_q == WB_MEM) & load_mis;
  // A stalled instruction keeps its write enable; rewriting the same value is harmless.
  assign Reg_write_Control = valid_q & regwrite_q & (wreg_q != RW'(REG_ZERO)) & ~AddrErr;
  assign WriteReg          = wreg_q;
  assign wb_valid          = valid_q;
  assign retire_count      = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        Clock;
  logic        Resetn;
  logic        Stall;
  logic        Flush;
  logic        in_valid;
  logic        in_RegWrite;
  logic [1:0]  in_WbSel;
  logic [2:0]  in_LoadType;
  logic [1:0]  in_AddrLow;
  logic [31:0] in_ALUResult;
  logic [31:0] in_MemData;
  logic [31:0] in_PCPlus8;
  logic [4:0]  in_WriteReg;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Reg_write_Control;
  logic        wb_valid;
  logic        AddrErr;
  logic [31:0] retire_count;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage #(.DW(32), .RW(5)) dut (
    .Clock             (Clock),
    .Resetn            (Resetn),
    .Stall             (Stall),
    .Flush             (Flush),
    .in_valid          (in_valid),
    .in_RegWrite       (in_RegWrite),
    .in_WbSel          (in_WbSel),
    .in_LoadType       (in_LoadType),
    .in_AddrLow        (in_AddrLow),
    .in_ALUResult      (in_ALUResult),
    .in_MemData        (in_MemData),
    .in_PCPlus8        (in_PCPlus8),
    .in_WriteReg       (in_WriteReg),
    .WriteReg          (WriteReg),
    .WriteData         (WriteData),
    .Reg_write_Control (Reg_write_Control),
    .wb_valid          (wb_valid),
    .AddrErr           (AddrErr),
    .retire_count      (retire_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: the instruction sitting in WB plus the retired count.
  typedef struct {
    bit          valid;
    bit          rw;
    bit [1:0]    wbsel;
    bit [2:0]    lt;
    bit [1:0]    al;
    bit [31:0]   alu;
    bit [31:0]   mem;
    bit [31:0]   pc8;
    bit [4:0]    wr;
  } slot_t;

  slot_t       m;
  bit [31:0]   m_count;

  function automatic bit is_misaligned(input slot_t s);
    case (s.lt)
      3'd1, 3'd2: return s.al[0];
      3'd3, 3'd4: return 1'b0;
      default:    return s.al != 2'd0;
    endcase
  endfunction

  function automatic bit [31:0] load_value(input slot_t s);
    bit [31:0] h;
    bit [31:0] b;
    h = (s.mem >> (int'(s.al[1]) * 16)) & 32'h0000_FFFF;
    b = (s.mem >> (int'(s.al) * 8)) & 32'h0000_00FF;
    case (s.lt)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return s.mem;
    endcase
  endfunction

  function automatic bit exp_err(input slot_t s);
    return s.valid && s.wbsel == 2'd1 && is_misaligned(s);
  endfunction

  function automatic bit [31:0] exp_data(input slot_t s);
    if (!s.valid) return 32'd0;
    if (s.wbsel == 2'd1) return load_value(s);
    if (s.wbsel == 2'd2) return s.pc8;
    return s.alu;
  endfunction

  function automatic bit exp_we(input slot_t s);
    return s.valid && s.rw && s.wr != 5'd0 && !exp_err(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".WriteReg"},  32'(WriteReg),          32'(m.wr));
    chk({tag, ".WriteData"}, WriteData,              exp_data(m));
    chk({tag, ".RegWrCtl"},  32'(Reg_write_Control), 32'(exp_we(m)));
    chk({tag, ".wb_valid"},  32'(wb_valid),          32'(m.valid));
    chk({tag, ".AddrErr"},   32'(AddrErr),           32'(exp_err(m)));
    chk({tag, ".retire"},    retire_count,           m_count);
  endtask

  task automatic model_reset();
    m = '{default: 0};
    m_count = 32'd0;
  endtask

  // Advance model and DUT by one edge, then compare every output.
  task automatic step(input string tag);
    if (m.valid && (!Stall || Flush)) m_count = m_count + 32'd1;
    if (Flush) m.valid = 1'b0;
    else if (!Stall) begin
      m.valid = in_valid;    m.rw = in_RegWrite; m.wbsel = in_WbSel;
      m.lt    = in_LoadType; m.al = in_AddrLow;  m.alu   = in_ALUResult;
      m.mem   = in_MemData;  m.pc8 = in_PCPlus8; m.wr    = in_WriteReg;
    end
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit rw, input bit [1:0] ws, input bit [2:0] lt,
                       input bit [1:0] al, input bit [31:0] alu, input bit [31:0] mem,
                       input bit [31:0] pc8, input bit [4:0] wr);
    in_valid = v; in_RegWrite = rw; in_WbSel = ws; in_LoadType = lt; in_AddrLow = al;
    in_ALUResult = alu; in_MemData = mem; in_PCPlus8 = pc8; in_WriteReg = wr;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom_range(0, 7)), 2'($urandom),
          $urandom, $urandom, $urandom, 5'($urandom));
  endtask

  task automatic load(input bit [2:0] lt, input bit [1:0] al);
    drive(1, 1, 2'd1, lt, al, 32'h0, 32'h80FF_7F01, 32'h0, 5'd9);
  endtask

  bit [31:0] base;

  initial begin
    model_reset();
    Stall = 0; Flush = 0;
    Resetn = 0;
    drive_random();

    // Reset with random inputs applied.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      drive_random();
      check_all("reset");
    end
    chk("reset.WriteData0", WriteData, 32'd0);
    chk("reset.retire0", retire_count, 32'd0);

    Resetn = 1;
    drive(1, 1, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd8);
    step("alu");
    chk("alu.data", WriteData, 32'h1234_5678);
    chk("alu.we", 32'(Reg_write_Control), 32'd1);
    chk("alu.reg", 32'(WriteReg), 32'd8);
    chk("alu.count_before", retire_count, 32'd0);

    // Load extension on 0x80FF7F01.
    load(3'd3, 2'd3); step("lb");  chk("lb.data",  WriteData, 32'hFFFF_FF80);
    chk("alu.count_after", retire_count, 32'd1);
    load(3'd4, 2'd3); step("lbu"); chk("lbu.data", WriteData, 32'h0000_0080);
    load(3'd1, 2'd2); step("lh");  chk("lh.data",  WriteData, 32'hFFFF_80FF);
    load(3'd2, 2'd2); step("lhu"); chk("lhu.data", WriteData, 32'h0000_80FF);
    load(3'd0, 2'd0); step("lw");  chk("lw.data",  WriteData, 32'h80FF_7F01);

    // Misaligned halfword: fault, no write, still retires.
    load(3'd1, 2'd1); step("lh_mis");
    chk("lh_mis.err", 32'(AddrErr), 32'd1);
    chk("lh_mis.we", 32'(Reg_write_Control), 32'd0);
    base = m_count;
    drive(1, 1, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0);
    step("r0");
    chk("lh_mis.retired", retire_count, base + 32'd1);
    chk("r0.we", 32'(Reg_write_Control), 32'd0);

    // Stall for three cycles: stable outputs, single retire.
    drive(1, 1, 2'd0, 3'd0, 2'd0, 32'hCAFE_0001, 32'h0, 32'h0, 5'd5);
    step("stall_load");
    base = m_count;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step("stall");
      chk("stall.data", WriteData, 32'hCAFE_0001);
      chk("stall.we", 32'(Reg_write_Control), 32'd1);
      chk("stall.count", retire_count, base);
    end
    Stall = 0;
    drive(0, 0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("unstall");
    chk("unstall.count", retire_count, base + 32'd1);

    // Flush together with Stall.
    drive(1, 1, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0, 5'd7);
    step("pre_flush");
    base = m_count;
    Stall = 1; Flush = 1;
    drive(1, 1, 2'd0, 3'd0, 2'd0, 32'h1111_2222, 32'h0, 32'h0, 5'd3);
    step("flush");
    chk("flush.valid", 32'(wb_valid), 32'd0);
    chk("flush.data", WriteData, 32'd0);
    chk("flush.count", retire_count, base + 32'd1);
    Stall = 0; Flush = 0;

    // Link and reserved select.
    drive(1, 1, 2'd2, 3'd0, 2'd0, 32'h9999_9999, 32'h0, 32'h0040_0018, 5'd31);
    step("link");
    chk("link.data", WriteData, 32'h0040_0018);
    drive(1, 1, 2'd3, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h7777_7777, 32'h6666_6666, 5'd4);
    step("rsvd");
    chk("rsvd.data", WriteData, 32'h0BAD_F00D);

    // Counter wrap: preload all-ones while a valid instruction sits in WB.
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_count = 32'hFFFF_FFFF;
    drive(0, 0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("wrap");
    chk("wrap.count", retire_count, 32'd0);

    // Asynchronous reset between edges.
    drive(1, 1, 2'd0, 3'd0, 2'd0, 32'hA5A5_5A5A, 32'h0, 32'h0, 5'd12);
    step("pre_arst");
    #1;
    Resetn = 0;
    model_reset();
    #1;
    check_all("arst");
    chk("arst.data", WriteData, 32'd0);
    #1;
    Resetn = 1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      Flush = ($urandom_range(0, 7) == 0);
      Stall = ($urandom_range(0, 5) == 0);
      step("rand");
    end
    Stall = 0; Flush = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
